// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC unit: reset PC default, FSM state codes, redirect-select codes.
package pc_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  localparam logic [0:0] ST_SEQ  = 1'b0;
  localparam logic [0:0] ST_SLOT = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BR   = 2'd1,
    SEL_J    = 2'd2,
    SEL_JR   = 2'd3
  } redirect_sel_t;

  // JumpReg outranks Jump, which outranks Branch.
  function automatic redirect_sel_t redirect_select(input logic jr, input logic j, input logic br);
    if (jr)      return SEL_JR;
    else if (j)  return SEL_J;
    else if (br) return SEL_BR;
    else         return SEL_NONE;
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target adder: base + offset, modulo 2^32.
// Latency: combinational; no backpressure.
module branch_target_adder (
  input  logic [31:0] base,
  input  logic [31:0] offset,
  output logic [31:0] sum
);

  assign sum = base + offset;

endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC register with JumpReg > Jump > Branch redirects; DELAY_SLOT_EN adds one delay-slot fetch.
// Latency: target reaches PC one edge after acceptance (two with DELAY_SLOT_EN); Stall only holds sequential advance.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] BranchBasePC,
  input  logic [31:0] BranchOffsetShifted,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] JumpRegAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        RedirectPending,
  output logic        AlignErr
);

  logic [31:0]   pc_q;
  logic [0:0]    state_q;
  logic          flush_q;
  logic          align_err_q;
  redirect_sel_t sel;
  logic [31:0]   br_target;
  logic [31:0]   j_target;
  logic [31:0]   jr_target;
  logic [31:0]   redirect_target;
  logic [31:0]   pc_plus4;
  logic          accept;

  branch_target_adder u_br_adder (
    .base   (BranchBasePC),
    .offset (BranchOffsetShifted),
    .sum    (br_target)
  );

  assign j_target  = {BranchBasePC[31:28], JumpIndex, 2'b00};
  assign jr_target = {JumpRegAddr[31:2], 2'b00};
  assign sel       = redirect_select(JumpReg, Jump, Branch);
  assign pc_plus4  = pc_q + 32'd4;

  // Redirects are only taken in SEQ; a pending delay slot ignores new requests.
  assign accept = (state_q == ST_SEQ) && (sel != SEL_NONE);

  always_comb begin
    redirect_target = '0;
    case (sel)
      SEL_BR:  redirect_target = br_target;
      SEL_J:   redirect_target = j_target;
      SEL_JR:  redirect_target = jr_target;
      default: redirect_target = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      align_err_q <= 1'b0;
    end else if (accept && (sel == SEL_JR) && (JumpRegAddr[1:0] != 2'b00)) begin
      align_err_q <= 1'b1;
    end
  end

`ifdef DELAY_SLOT_EN
  logic [31:0] target_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_SEQ;
      flush_q  <= 1'b0;
      target_q <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        ST_SEQ: begin
          if (accept) begin
            target_q <= redirect_target;
            state_q  <= ST_SLOT;
          end
          if (!Stall) pc_q <= pc_plus4;
        end
        ST_SLOT: begin
          if (!Stall) begin
            pc_q    <= target_q;
            state_q <= ST_SEQ;
          end
        end
        default: state_q <= ST_SEQ;
      endcase
    end
  end

  assign RedirectPending = (state_q == ST_SLOT);
`else
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_SEQ;
      flush_q <= 1'b0;
    end else begin
      flush_q <= accept;
      if (accept)      pc_q <= redirect_target;
      else if (!Stall) pc_q <= pc_plus4;
    end
  end

  assign RedirectPending = 1'b0;
`endif

  assign PC       = pc_q;
  assign PCPlus4  = pc_plus4;
  assign Flush    = flush_q;
  assign AlignErr = align_err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed vector bench for pc_next_unit; expectations follow DELAY_SLOT_EN when it is defined.
module tb_pc_next_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Branch;
  logic        Jump;
  logic        JumpReg;
  logic [31:0] BranchBasePC;
  logic [31:0] BranchOffsetShifted;
  logic [25:0] JumpIndex;
  logic [31:0] JumpRegAddr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        RedirectPending;
  logic        AlignErr;

  int n_checks = 0;
  int n_pass   = 0;

  pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .Stall               (Stall),
    .Branch              (Branch),
    .Jump                (Jump),
    .JumpReg             (JumpReg),
    .BranchBasePC        (BranchBasePC),
    .BranchOffsetShifted (BranchOffsetShifted),
    .JumpIndex           (JumpIndex),
    .JumpRegAddr         (JumpRegAddr),
    .PC                  (PC),
    .PCPlus4             (PCPlus4),
    .Flush               (Flush),
    .RedirectPending     (RedirectPending),
    .AlignErr            (AlignErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [3:0]  ctl;   // {Stall, Branch, Jump, JumpReg}
    logic [31:0] base;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] jra;
    logic [31:0] pc;
    logic        flush;
    logic        rp;
    logic        aerr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string n, input logic [3:0] ctl, input logic [31:0] base,
                              input logic [31:0] off, input logic [25:0] idx, input logic [31:0] jra,
                              input logic [31:0] pc, input logic flush, input logic rp, input logic aerr);
    vec_t v;
    v.name = n; v.ctl = ctl; v.base = base; v.off = off; v.idx = idx; v.jra = jra;
    v.pc = pc; v.flush = flush; v.rp = rp; v.aerr = aerr;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] base, input logic [31:0] off,
                       input logic [25:0] idx, input logic [31:0] jra);
    {Stall, Branch, Jump, JumpReg} = ctl;
    BranchBasePC = base; BranchOffsetShifted = off; JumpIndex = idx; JumpRegAddr = jra;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_outs(input string n, input logic [31:0] pc, input logic flush,
                            input logic rp, input logic aerr);
    check({n, ".PC"}, PC, pc);
    check({n, ".Flush"}, {31'd0, Flush}, {31'd0, flush});
    check({n, ".RedirectPending"}, {31'd0, RedirectPending}, {31'd0, rp});
    check({n, ".AlignErr"}, {31'd0, AlignErr}, {31'd0, aerr});
  endtask

  initial begin
    Reset = 1'b1;
    drive(4'b0000, '0, '0, '0, '0);

`ifdef DELAY_SLOT_EN
    add("idle0",      4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0004, 0, 0, 0);
    add("idle1",      4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0008, 0, 0, 0);
    add("idle2",      4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_000C, 0, 0, 0);
    add("stall",      4'b1000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_000C, 0, 0, 0);
    add("br_slot",    4'b0100, 32'h0000_0010, 32'h20, 26'h0,   32'h0,         32'h0000_0010, 0, 1, 0);
    add("br_ignored", 4'b0100, 32'h0000_0500, 32'h0,  26'h0,   32'h0,         32'h0000_0030, 0, 0, 0);
    add("seq_after",  4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0034, 0, 0, 0);
    add("j_over_br",  4'b0110, 32'h4000_0008, 32'h20, 26'h100, 32'h0,         32'h0000_0038, 0, 1, 0);
    add("slot_stall", 4'b1000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0038, 0, 1, 0);
    add("j_land",     4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h4000_0400, 0, 0, 0);
    add("jr_unalign", 4'b0001, 32'h0,         32'h0,  26'h0,   32'h0000_1003, 32'h4000_0404, 0, 1, 1);
    add("jr_land",    4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_1000, 0, 0, 1);
    add("br_wrap",    4'b0100, 32'hFFFF_FFFC, 32'h8,  26'h0,   32'h0,         32'h0000_1004, 0, 1, 1);
    add("wrap_land",  4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0004, 0, 0, 1);
`else
    add("idle0",      4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0004, 0, 0, 0);
    add("idle1",      4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0008, 0, 0, 0);
    add("idle2",      4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_000C, 0, 0, 0);
    add("stall",      4'b1000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_000C, 0, 0, 0);
    add("br",         4'b0100, 32'h0000_0010, 32'h20, 26'h0,   32'h0,         32'h0000_0030, 1, 0, 0);
    add("flush_drop", 4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0034, 0, 0, 0);
    add("br_wrap",    4'b0100, 32'hFFFF_FFFC, 32'h8,  26'h0,   32'h0,         32'h0000_0004, 1, 0, 0);
    add("stall2",     4'b1000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0004, 0, 0, 0);
    add("j_over_br",  4'b0110, 32'h4000_0008, 32'h20, 26'h100, 32'h0,         32'h4000_0400, 1, 0, 0);
    add("jr_over_all",4'b0111, 32'h4000_0008, 32'h20, 26'h100, 32'h0000_2000, 32'h0000_2000, 1, 0, 0);
    add("br_stalled", 4'b1100, 32'h0000_0100, 32'h10, 26'h0,   32'h0,         32'h0000_0110, 1, 0, 0);
    add("seq3",       4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0114, 0, 0, 0);
    add("jr_unalign", 4'b0001, 32'h0,         32'h0,  26'h0,   32'h0000_1003, 32'h0000_1000, 1, 0, 1);
    add("aerr_stick", 4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_1004, 0, 0, 1);
    add("jr_top",     4'b0001, 32'h0,         32'h0,  26'h0,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 1);
    add("pc_wrap",    4'b0000, 32'h0,         32'h0,  26'h0,   32'h0,         32'h0000_0000, 0, 0, 1);
`endif

    step();
    check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.PCPlus4", PCPlus4, 32'h0000_0004);
    Reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].ctl, vq[i].base, vq[i].off, vq[i].idx, vq[i].jra);
      step();
      check_outs(vq[i].name, vq[i].pc, vq[i].flush, vq[i].rp, vq[i].aerr);
      check({vq[i].name, ".PCPlus4"}, PCPlus4, vq[i].pc + 32'd4);
    end

    // Reset wins over simultaneous requests and clears the sticky error.
    drive(4'b0111, 32'h4000_0008, 32'h20, 26'h100, 32'h0000_3001);
    Reset = 1'b1;
    step();
    check_outs("rst_override", 32'h0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

    // Redirect accepted, then Reset lands while the redirect is pending.
    drive(4'b0100, 32'h0000_0200, 32'h40, 26'h0, 32'h0);
    step();
`ifdef DELAY_SLOT_EN
    check_outs("slot_pending", 32'h0000_0004, 1'b0, 1'b1, 1'b0);
`else
    check_outs("slot_pending", 32'h0000_0240, 1'b1, 1'b0, 1'b0);
`endif
    drive(4'b0000, '0, '0, '0, '0);
    Reset = 1'b1;
    step();
    check_outs("rst_in_slot", 32'h0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    step();
    check_outs("target_discarded", 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("seq_resume", 32'h0000_0008, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
